// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 decryption core.
// Captures a ciphertext and an 80-bit key on a start pulse. It then runs the
// key schedule forward for 31 cycles to reach K32, and then runs 31 inverse
// rounds while it unwinds the key schedule. The last whitening happens in FIN.
// The result is ready 63 edges after the capture edge.
// Ports:
//   ck   - rising-edge clock
//   rst  - synchronous active-high reset
//   sta  - start pulse, sampled only while idle
//   inp  - 64-bit ciphertext, index 0 = MSB
//   key  - 80-bit cipher key, index 0 = MSB (paper bit k79)
//   rdy  - result valid, held until the next accepted start
//   out  - recovered plaintext, registered
module present_dec (
   input  logic        ck,
   input  logic        rst,
   input  logic        sta,
   input  logic [0:63] inp,
   input  logic [0:79] key,
   output logic        rdy,
   output logic [0:63] out
);

   typedef enum logic [1:0] {StIdle, StKeyExp, StDec, StFin} st_e;

   st_e         st_q, st_d;
   logic [63:0] state_q;   // bit j = paper bit j
   logic [79:0] kreg_q;    // bit j = paper bit kj
   logic [4:0]  rc_q;

   logic        do_load, do_kexp, do_dec, do_fin;
   logic        last_kexp, last_dec;

   logic [79:0] k_fwd, k_x, k_inv;
   logic [63:0] d_x, d_p, d_s;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Forward key update: rotate left 61, S-box the top nibble, XOR the
   // counter into k19..k15.
   always_comb begin
      k_fwd          = {kreg_q[18:0], kreg_q[79:19]};
      k_fwd[79:76]   = sbox(k_fwd[79:76]);
      k_fwd[19:15]   = k_fwd[19:15] ^ rc_q;
   end

   // Inverse key update: undo the forward steps in reverse order.
   always_comb begin
      k_x          = kreg_q;
      k_x[19:15]   = k_x[19:15] ^ rc_q;
      k_x[79:76]   = inv_sbox(k_x[79:76]);
      k_inv        = {k_x[60:0], k_x[79:61]};
   end

   // Inverse round: add the key, undo pLayer, then undo sBoxLayer.
   // pLayer sends bit j to 16*j mod 63, so bit j is pulled back from there.
   always_comb begin
      d_x     = state_q ^ kreg_q[79:16];
      d_p     = '0;
      d_p[63] = d_x[63];
      for (int j = 0; j < 63; j++) begin
         d_p[j] = d_x[(16 * j) % 63];
      end
      d_s = '0;
      for (int n = 0; n < 16; n++) begin
         d_s[4*n +: 4] = inv_sbox(d_p[4*n +: 4]);
      end
   end

   assign last_kexp = (rc_q == 5'd31);
   assign last_dec  = (rc_q == 5'd1);

   // FSM state register
   always_ff @(posedge ck) begin
      if (rst) begin
         st_q <= StIdle;
      end else begin
         st_q <= st_d;
      end
   end

   // FSM next state
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle:   if (sta) st_d = StKeyExp;
         StKeyExp: if (last_kexp) st_d = StDec;
         StDec:    if (last_dec) st_d = StFin;
         StFin:    st_d = StIdle;
         default:  st_d = StIdle;
      endcase
   end

   // FSM outputs: datapath controls
   always_comb begin
      do_load = 1'b0;
      do_kexp = 1'b0;
      do_dec  = 1'b0;
      do_fin  = 1'b0;
      unique case (st_q)
         StIdle:   do_load = sta;
         StKeyExp: do_kexp = 1'b1;
         StDec:    do_dec  = 1'b1;
         StFin:    do_fin  = 1'b1;
         default:  ;
      endcase
   end

   // Datapath
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q <= '0;
         kreg_q  <= '0;
         rc_q    <= '0;
         rdy     <= 1'b0;
         out     <= '0;
      end else begin
         if (do_load) begin
            state_q <= inp;
            kreg_q  <= key;
            rc_q    <= 5'd1;
            rdy     <= 1'b0;
         end
         if (do_kexp) begin
            kreg_q <= k_fwd;
            // The counter stays at 31 because DEC starts from round 31.
            if (!last_kexp) rc_q <= rc_q + 5'd1;
         end
         if (do_dec) begin
            state_q <= d_s;
            kreg_q  <= k_inv;
            rc_q    <= rc_q - 5'd1;
         end
         if (do_fin) begin
            out <= state_q ^ kreg_q[79:16];
            rdy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_present_dec.sv
// tb_present_dec: directed bench for present_dec. It covers known-answer vectors,
// back-to-back issue, start pulses that arrive while busy, aborts by reset,
// and an encrypt/decrypt loopback. A scoreboard queue holds each expected
// plaintext from issue until rdy rises.
module tb_present_dec;

   logic        ck  = 1'b0;
   logic        rst = 1'b1;
   logic        sta = 1'b0;
   logic [0:63] inp = '0;
   logic [0:79] key = '0;
   logic        rdy;
   logic [0:63] out;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];

   localparam logic [79:0] KOnes = {80{1'b1}};
   localparam logic [63:0] POnes = {64{1'b1}};

   always #5 ck = ~ck;

   present_dec dut (
      .ck  (ck),
      .rst (rst),
      .sta (sta),
      .inp (inp),
      .key (key),
      .rdy (rdy),
      .out (out)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   // Reference encryption, used only to build loopback stimulus.
   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k0);
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] k;
      s = pt;
      k = k0;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
         t = '0;
         for (int j = 0; j < 63; j++) t[(16 * j) % 63] = s[j];
         t[63] = s[63];
         s = t;
         k = {k[18:0], k[79:19]};
         k[79:76] = sb(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   // Issues one decryption, then waits (bounded) for rdy and scores latency and
   // result. With disturb set, it pulses sta with fresh inp/key at run cycles 5
   // and 40.
   task automatic run_op(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] expv,
                         input bit disturb, input string tag);
      int          n;
      logic [95:0] r;
      logic [63:0] want;
      inp = ct;
      key = k;
      sta = 1'b1;
      step();
      sta = 1'b0;
      check({tag, "_rdy_fall"}, rdy, 0);
      exp_q.push_back(expv);
      n = 0;
      while (rdy !== 1'b1 && n < 100) begin
         if (disturb && (n == 5 || n == 40)) begin
            r   = {$urandom, $urandom, $urandom};
            inp = r[63:0];
            r   = {$urandom, $urandom, $urandom};
            key = r[79:0];
            sta = 1'b1;
         end else begin
            sta = 1'b0;
         end
         step();
         n++;
      end
      sta = 1'b0;
      check({tag, "_latency"}, n, 63);
      want = exp_q.pop_front();
      check({tag, "_out"}, out, want);
   endtask

   // Starts an operation and hits it with reset after cyc post-capture edges.
   task automatic abort(input int cyc, input logic [63:0] ct, input logic [79:0] k,
                        input string tag);
      bit seen;
      inp = ct;
      key = k;
      sta = 1'b1;
      step();
      sta = 1'b0;
      repeat (cyc) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check({tag, "_rdy"}, rdy, 0);
      check({tag, "_out"}, out, 0);
      seen = 1'b0;
      repeat (70) begin
         step();
         if (rdy !== 1'b0) seen = 1'b1;
      end
      check({tag, "_no_late_rdy"}, seen, 0);
   endtask

   initial begin
      logic [63:0] pt;
      logic [63:0] ct;
      logic [79:0] k;
      logic [95:0] r;
      bit          bad;

      rst = 1'b1;
      repeat (3) step();
      check("reset_rdy", rdy, 0);
      check("reset_out", out, 0);
      rst = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         step();
         if (rdy !== 1'b0 || out !== 64'h0) bad = 1'b1;
      end
      check("idle_after_reset", bad, 0);

      run_op(64'h5579C1387B228445, 80'h0, 64'h0, 1'b0, "kat0");
      run_op(64'hA112FFC72F68417B, 80'h0, POnes, 1'b0, "kat1");
      run_op(64'hE72C46C0F5945049, KOnes, 64'h0, 1'b0, "kat2_b2b");

      run_op(64'h3333DCD3213210D2, KOnes, POnes, 1'b1, "kat3_disturb");
      repeat (7) step();
      check("hold_rdy", rdy, 1);
      check("hold_out", out, POnes);

      abort(19, 64'h5579C1387B228445, 80'h0, "rst_kexp");
      run_op(64'hA112FFC72F68417B, 80'h0, POnes, 1'b0, "after_rst_kexp");
      abort(40, 64'h3333DCD3213210D2, KOnes, "rst_dec");
      run_op(64'hE72C46C0F5945049, KOnes, 64'h0, 1'b0, "after_rst_dec");

      for (int i = 0; i < 100; i++) begin
         r  = {$urandom, $urandom, $urandom};
         pt = r[63:0];
         r  = {$urandom, $urandom, $urandom};
         k  = r[79:0];
         ct = enc(pt, k);
         run_op(ct, k, pt, 1'b0, $sformatf("loop%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/present_dec.md
# present_dec

Iterative round-based PRESENT-80 decryption core, the inverse of the PRESENT-80 encryption core. It accepts a 64-bit ciphertext and the 80-bit cipher key with a one-cycle start pulse. It derives the final round key internally by running the key schedule forward, then runs the 31 inverse rounds. It exposes the same start/ready handshake as the encryption core, so both can sit side by side in the datapath and in the bench.

## Interface
- No parameters; block is fixed to PRESENT-80 (64-bit block, 80-bit key, 31 rounds).
- ck   in   1   rising-edge clock; single clock domain.
- rst  in   1   reset; synchronous, active-high.
- sta  in   1   start pulse; sampled on rising ck when idle.
- inp  in   [0:63]  ciphertext; index 0 = MSB.
- key  in   [0:79]  cipher key; index 0 = MSB (paper bit k79).
- rdy  out  1   result valid; held until next accepted sta.
- out  out  [0:63]  recovered plaintext; registered.

## Operation
- Registers: state[0:63], kreg[0:79], round counter rc[4:0], FSM, out[0:63], rdy.
- Bit mapping: paper bit j of an n-bit vector = index n-1-j.
- FSM states: IDLE → KEYEXP → DEC → FIN → IDLE.
- IDLE:
  - If sta=1, load state<=inp, kreg<=key, rc<=1, rdy<=0, go to KEYEXP.
  - out keeps its previous value.
- KEYEXP (31 cycles, rc=1..31), forward key update each cycle:
  - Rotate kreg left by 61.
  - Apply S-box to indices [0:3].
  - XOR rc into indices [60:64] (paper k19..k15).
  - When rc=31, set rc<=31 and go to DEC; kreg now holds K32 (round key = kreg[0:63]).
- DEC (31 cycles, rc=31 down to 1), each cycle:
  - state <= invS(invP(state ^ kreg[0:63])).
  - kreg <= inverse update: XOR rc into [60:64], inverse S-box on [0:3], rotate right by 61.
  - rc decrements.
  - When rc=1, go to FIN; kreg now holds K1.
- FIN (1 cycle): out <= state ^ kreg[0:63], rdy<=1, go to IDLE.
- Operators:
  - invS: the inverse PRESENT S-box on all 16 nibbles, nibble 0 = index [0:3].
  - invP: inverse bit permutation. Paper bit position P(i) moves back to i, where P(i)=16i mod 63 for i<63 and P(63)=63.
- sta while in KEYEXP/DEC/FIN: ignored; inp/key changes there have no effect (operands captured at start).
- sta asserted for multiple cycles while idle: each idle-cycle assertion starts a new operation. Only the first takes effect during busy.

## Timing
- Reset (rst=1 at rising ck): FSM=IDLE, rdy=0, out=0, state=0, kreg=0, rc=0. Takes priority over everything, including mid-operation; the aborted result is discarded.
- Edge E0: sta captured. rdy falls at E0.
- KEYEXP occupies E1..E31; DEC occupies E32..E62; FIN output is registered at E63.
- rdy=1 and out valid after E63: fixed 63-cycle latency from the capture edge.
- Back-to-back: a new sta is accepted on the first edge after FIN (the IDLE cycle). Minimum issue interval is 64 cycles.
- rdy stays high, and out is stable, across any number of idle cycles until the next accepted sta.
- rc is a 5-bit value XORed unsigned into the 5 key bits; no other arithmetic.

## Test plan
- Reset: hold rst 3 cycles, then release with sta=0 → rdy=0, out=0, and no state change for 10 cycles.
- inp=5579C1387B228445, key=0, pulse sta → rdy rises exactly 63 edges after capture, out=0000000000000000.
- inp=A112FFC72F68417B, key=0 → out=FFFFFFFFFFFFFFFF. Then inp=E72C46C0F5945049, key=FFFFFFFFFFFFFFFFFFFF → out=0000000000000000. Send the second sta on the first idle cycle after rdy.
- inp=3333DCD3213210D2, key all-ones → out=FFFFFFFFFFFFFFFF. Toggle inp/key and pulse sta at cycles 5 and 40 of the run → result unchanged, latency still 63.
- Assert rst at cycle 20 of KEYEXP and separately at cycle 10 of DEC → rdy=0, out=0 next edge. A fresh sta then gives the correct result at normal latency.
- Loopback: encryption core output fed to present_dec with the same key, 100 random inp/key pairs → out equals the original plaintext every time.
